// File: rtl/instr_fetch.sv
// Instruction fetch stage: program counter, synchronous ROM addressing, registered instruction/opcode.
// Optional RUN-cycle counter is built only when INSTR_FETCH_CYCLE_CNT_EN is defined.
module instr_fetch #(
    parameter int                 PC_W       = 10,
    parameter int                 INSTR_W    = 9,
    parameter logic [PC_W-1:0]    START_ADDR = '0,
    parameter logic [INSTR_W-1:0] HALT_INSTR = 9'h1FF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [2:0]         opcode,
    output logic [PC_W-1:0]    instr_pc,
    output logic               instr_valid,
    output logic               done,
    output logic [15:0]        cycle_count
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]      state;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] pc_next;
    logic            in_run;
    logic            enter_run;
    logic            do_branch;
    logic            do_halt;
    logic            do_fetch;

    // Saturating increment used by the optional cycle counter.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign in_run    = (state == ST_RUN);
    assign enter_run = ((state == ST_IDLE) || (state == ST_DONE)) && start;
    assign pc_inc    = pc + PC_W'(1);

    // Per-edge action priority while running: stall > branch > halt > advance.
    always_comb begin
        do_branch = 1'b0;
        do_halt   = 1'b0;
        do_fetch  = 1'b0;
        if (in_run && !stall) begin
            if (instr_valid && branch_taken)
                do_branch = 1'b1;
            else if (instr_valid && (instr == HALT_INSTR))
                do_halt = 1'b1;
            else
                do_fetch = 1'b1;
        end
    end

    always_comb begin
        pc_next = START_ADDR;
        if (in_run) begin
            if (stall || do_halt)
                pc_next = pc;
            else if (do_branch)
                pc_next = branch_target;
            else
                pc_next = pc_inc;
        end
    end

    // The ROM registers its address, so presenting pc_next makes imem_rdata track mem[pc].
    assign imem_addr = pc_next;
    assign opcode    = instr[INSTR_W-1 -: 3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            done  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start)
                        state <= ST_RUN;
                end
                ST_RUN: begin
                    if (do_halt) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        state <= ST_RUN;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pc <= START_ADDR;
        else
            pc <= pc_next;
    end

    // A branch or halt drops the word already in flight; the instruction register itself is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
        end else if (do_fetch) begin
            instr       <= imem_rdata;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
        end else if (do_branch || do_halt) begin
            instr_valid <= 1'b0;
        end
    end

`ifdef INSTR_FETCH_CYCLE_CNT_EN
    logic [15:0] cyc_cnt;

    // Counts every edge spent in RUN, stalls included; restarts on each entry into RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cyc_cnt <= 16'h0000;
        else if (enter_run)
            cyc_cnt <= 16'h0000;
        else if (in_run)
            cyc_cnt <= sat_inc(cyc_cnt);
    end

    assign cycle_count = cyc_cnt;
`else
    logic unused_cnt;
    assign unused_cnt  = enter_run & (sat_inc(16'h0000) == 16'h0000);
    assign cycle_count = 16'h0000;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch against a cycle-level behavioural model of the fetch rules.
module tb_instr_fetch;

    localparam int         PC_W  = 10;
    localparam int         IW    = 9;
    localparam logic [8:0] HALT  = 9'h1FF;
    localparam logic [9:0] START = 10'h000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          stall = 1'b0;
    logic          branch_taken = 1'b0;
    logic [9:0]    branch_target = '0;
    logic [9:0]    imem_addr;
    logic [8:0]    imem_rdata;
    logic [8:0]    instr;
    logic [2:0]    opcode;
    logic [9:0]    instr_pc;
    logic          instr_valid;
    logic          done;
    logic [15:0]   cycle_count;

    logic [8:0]    mem [0:1023];

    int errors = 0;
    int checks = 0;

    bit         m_run, m_done, m_vld;
    logic [9:0] m_fa, m_ipc;
    logic [8:0] m_instr;
    int         m_cnt;

    instr_fetch #(.PC_W(PC_W), .INSTR_W(IW), .START_ADDR(START), .HALT_INSTR(HALT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .instr(instr), .opcode(opcode), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .done(done), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) imem_rdata <= mem[imem_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_cnt();
`ifdef INSTR_FETCH_CYCLE_CNT_EN
        return m_cnt;
`else
        return 0;
`endif
    endfunction

    function automatic logic [9:0] exp_addr(input bit st, input bit br, input logic [9:0] tg);
        if (!m_run) return START;
        if (st) return m_fa;
        if (m_vld && br) return tg;
        if (m_vld && m_instr == HALT) return m_fa;
        return m_fa + 10'd1;
    endfunction

    task automatic model_reset();
        m_run = 0; m_done = 0; m_vld = 0;
        m_fa = START; m_ipc = '0; m_instr = '0; m_cnt = 0;
    endtask

    // One clock edge of the program-level rules; the ROM is assumed to deliver mem[fetch address].
    task automatic model_step(input bit s, input bit st, input bit br, input logic [9:0] tg);
        if (!m_run) begin
            m_fa = START;
            if (s) begin
                m_run = 1; m_done = 0; m_cnt = 0;
            end
        end else begin
            if (m_cnt < 65535) m_cnt++;
            if (st) begin
            end else if (m_vld && br) begin
                m_fa = tg; m_vld = 0;
            end else if (m_vld && m_instr == HALT) begin
                m_run = 0; m_done = 1; m_vld = 0;
            end else begin
                m_instr = mem[m_fa]; m_ipc = m_fa; m_vld = 1; m_fa = m_fa + 10'd1;
            end
        end
    endtask

    task automatic check_outputs();
        check("instr_valid", instr_valid, m_vld);
        check("instr_pc", instr_pc, m_ipc);
        check("instr", instr, m_instr);
        check("opcode", opcode, m_instr[8:6]);
        check("done", done, m_done);
        check("cycle_count", cycle_count, exp_cnt());
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic cycle(input bit s, input bit st, input bit br, input logic [9:0] tg);
        check_outputs();
        start = s; stall = st; branch_taken = br; branch_target = tg;
        #1;
        check("imem_addr", imem_addr, exp_addr(st, br, tg));
        @(posedge clk);
        model_step(s, st, br, tg);
        @(negedge clk);
    endtask

    task automatic do_reset();
        start = 0; stall = 0; branch_taken = 0; branch_target = '0;
        rst_n = 0;
        model_reset();
        #1;
        check_outputs();
        check("rst_imem_addr", imem_addr, START);
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic fill_mem(input int halt_pct);
        for (int i = 0; i < 1024; i++)
            mem[i] = ($urandom_range(0, 99) < halt_pct) ? HALT : 9'($urandom_range(0, 510));
    endtask

    task automatic run_until(input logic [9:0] pc);
        bit found = 0;
        for (int k = 0; k < 200 && !found; k++) begin
            if (instr_valid && instr_pc == pc) found = 1;
            else cycle(0, 0, 0, '0);
        end
        if (!found) check("run_until_timeout", 0, 1);
    endtask

    logic [8:0] held;

    initial begin
        @(negedge clk);

        // Straight program with halt, then restart from DONE
        fill_mem(0);
        mem[0] = 9'h040; mem[1] = 9'h0C3; mem[2] = 9'h1FF;
        do_reset();
        cycle(1, 0, 0, '0);
        check("t1_first_bubble", instr_valid, 0);
        cycle(0, 0, 0, '0);
        check("t1_i0", instr, 9'h040); check("t1_pc0", instr_pc, 0); check("t1_v0", instr_valid, 1);
        check("t1_op0", opcode, 3'd1);
        cycle(0, 0, 0, '0);
        check("t1_i1", instr, 9'h0C3); check("t1_pc1", instr_pc, 1);
        cycle(0, 1'b0, 0, '0);
        check("t1_i2", instr, 9'h1FF); check("t1_v2", instr_valid, 1);
        cycle(0, 0, 0, '0);
        check("t1_done", done, 1); check("t1_v_done", instr_valid, 0);
        cycle(0, 1, 1, 10'h3);
        check("t1_done_held", done, 1);
        cycle(1, 0, 0, '0);
        check("t1_restart_done", done, 0);
        cycle(0, 0, 0, '0);
        check("t1_restart_i0", instr, 9'h040);

        // Branch redirect with one bubble
        fill_mem(0);
        mem[5] = 9'h1C5; mem[10'h20] = 9'h0AB;
        do_reset();
        cycle(1, 0, 0, '0);
        run_until(10'd5);
        check("t2_br_instr", instr, 9'h1C5);
        cycle(0, 0, 1, 10'h020);
        check("t2_bubble", instr_valid, 0);
        cycle(0, 0, 0, '0);
        check("t2_tgt_pc", instr_pc, 10'h020); check("t2_tgt_instr", instr, 9'h0AB);
        check("t2_tgt_v", instr_valid, 1);

        // Stall holds everything
        do_reset();
        cycle(1, 0, 0, '0);
        run_until(10'd7);
        held = instr;
        for (int k = 0; k < 3; k++) begin
            cycle(0, 1, 0, '0);
            check("t3_stall_pc", instr_pc, 7); check("t3_stall_i", instr, held);
            check("t3_stall_v", instr_valid, 1);
        end
        cycle(0, 0, 0, '0);
        check("t3_release_pc", instr_pc, 8); check("t3_release_i", instr, mem[8]);

        // Stall beats branch; branch taken on first unstalled edge
        cycle(0, 1, 1, 10'h040);
        check("t4_stalled_pc", instr_pc, 8); check("t4_stalled_v", instr_valid, 1);
        cycle(0, 0, 1, 10'h040);
        check("t4_bubble", instr_valid, 0);
        cycle(0, 0, 0, '0);
        check("t4_tgt", instr_pc, 10'h040);

        // PC wrap at top of address space
        cycle(0, 0, 1, 10'h3FD);
        cycle(0, 0, 0, '0); check("t5_3fd", instr_pc, 10'h3FD);
        cycle(0, 0, 0, '0); check("t5_3fe", instr_pc, 10'h3FE);
        cycle(0, 0, 0, '0); check("t5_3ff", instr_pc, 10'h3FF);
        cycle(0, 0, 0, '0); check("t5_wrap", instr_pc, 10'h000); check("t5_wrap_v", instr_valid, 1);
        check("t5_wrap_i", instr, mem[0]);

        // Reset mid-run, then cycle counter over 10 RUN edges
        run_until(10'h033);
        do_reset();
        check("t6_pc", instr_pc, 0); check("t6_instr", instr, 0); check("t6_v", instr_valid, 0);
        check("t6_done", done, 0); check("t6_cnt", cycle_count, 0);
        cycle(1, 0, 0, '0);
        for (int k = 0; k < 10; k++) cycle((k == 4), (k == 6), 0, '0);
`ifdef INSTR_FETCH_CYCLE_CNT_EN
        check("t6_cnt10", cycle_count, 16'd10);
`else
        check("t6_cnt_tied", cycle_count, 16'd0);
`endif

        // Randomized traffic
        fill_mem(4);
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) do_reset();
            cycle($urandom_range(0, 99) < (m_run ? 10 : 30),
                  $urandom_range(0, 99) < 20,
                  $urandom_range(0, 99) < 15,
                  10'($urandom_range(0, 1023)));
        end
        check_outputs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
